// File: rtl/mem_port_ctrl_if.sv
// mem_port_ctrl_if: request/response and RAM-side signals of the memory port controller.
//   req_*        : load/store request from the control unit (valid/ready handshake)
//   rsp_*        : one-cycle completion pulse with load data / range error
//   mem_*        : address, data and level-sensitive strobes toward the RAM
// slave modport is the controller; master modport is the requester/RAM side.
interface mem_port_ctrl_if;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_error;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_in;
  logic          mem_read;
  logic          mem_write;
  logic [DW-1:0] mem_data_out;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mem_data_out,
    output req_ready, rsp_valid, rsp_rdata, rsp_error,
           mem_address, mem_data_in, mem_read, mem_write
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, mem_data_out,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error,
           mem_address, mem_data_in, mem_read, mem_write
  );
endinterface

// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: CPU-side initiator for a level-sensitive 32-bit RAM.
// Accepts one load/store at a time, drives address/data one cycle ahead of
// the strobe (SETUP), holds the strobe for WAIT_CYCLES (ACCESS), keeps the
// address stable one more cycle (HOLD), then pulses the response (RESP).
// Out-of-range addresses skip the RAM entirely and respond with an error.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : mem_port_ctrl_if.slave (request, response and RAM signals)
module mem_port_ctrl #(
  parameter int unsigned DEPTH       = 512,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  mem_port_ctrl_if.slave bus
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_ACCESS = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          write_q, write_d;
  logic          req_ready_q, req_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_error_q, rsp_error_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [AW-1:0] mem_address_q, mem_address_d;
  logic [DW-1:0] mem_data_in_q, mem_data_in_d;
  logic          mem_read_q, mem_read_d;
  logic          mem_write_q, mem_write_d;
  logic          in_range_c;

  // Unsigned full-width compare: 0xFFFFFFFF is out of range.
  assign in_range_c = bus.req_addr < AW'(DEPTH);

  // State and registered-output update; reset drops strobes immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      write_q       <= 1'b0;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_error_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      mem_address_q <= '0;
      mem_data_in_q <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      write_q       <= write_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_error_q   <= rsp_error_d;
      rsp_rdata_q   <= rsp_rdata_d;
      mem_address_q <= mem_address_d;
      mem_data_in_q <= mem_data_in_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
    end
  end

  // Next state and next output values; outputs are set on the edge that
  // enters the state in which they must be visible.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    write_d       = write_q;
    req_ready_d   = req_ready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_error_d   = rsp_error_q;
    rsp_rdata_d   = rsp_rdata_q;
    mem_address_d = mem_address_q;
    mem_data_in_d = mem_data_in_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          write_d     = bus.req_write;
          req_ready_d = 1'b0;
          // Cleared so stores and errors respond with zero data.
          rsp_rdata_d = '0;
          if (in_range_c) begin
            state_d       = S_SETUP;
            mem_address_d = bus.req_addr;
            mem_data_in_d = bus.req_wdata;
          end else begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
          end
        end
      end
      S_SETUP: begin
        state_d     = S_ACCESS;
        mem_read_d  = !write_q;
        mem_write_d = write_q;
        cnt_d       = CW'(WAIT_CYCLES - 1);
      end
      S_ACCESS: begin
        if (cnt_q == '0) begin
          state_d     = S_HOLD;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (!write_q) begin
            rsp_rdata_d = bus.mem_data_out;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_HOLD: begin
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
      end
      S_RESP: begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b0;
        rsp_error_d = 1'b0;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = S_IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_error_d = 1'b0;
        req_ready_d = 1'b1;
      end
    endcase
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_error   = rsp_error_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.mem_address = mem_address_q;
  assign bus.mem_data_in = mem_data_in_q;
  assign bus.mem_read    = mem_read_q;
  assign bus.mem_write   = mem_write_q;

endmodule
